// File: rtl/alarm_responder.sv
// Alarm responder: entry delay, timed siren, retrigger from silent, monitoring-link dial handshake.
// Optional strobe output is built only when ALARM_RESPONDER_STROBE_EN is defined.
module alarm_responder #(
  parameter int unsigned ENTRY_DLY  = 16,
  parameter int unsigned SIREN_TIME = 64,
  parameter int unsigned STROBE_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ALARM,
  input  logic       PANIC,
  input  logic [2:0] ZONE,
  input  logic       DISARM,
  input  logic       ACK,
  output logic       SIREN,
  output logic       STROBE,
  output logic       DIAL_REQ,
  output logic [2:0] ZONE_LATCH,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_SOUND  = 2'd2,
    ST_SILENT = 2'd3
  } state_t;

  localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_DLY - 1);
  localparam logic [15:0] SIREN_LOAD = 16'(SIREN_TIME - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  zone_q, zone_d;
  logic        alarm_prev_q;
  logic        siren_q;
  logic        dial_q, dial_d;
  logic        dialed_q, dialed_d;

`ifdef ALARM_RESPONDER_STROBE_EN
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_DIV - 1);
  logic       strobe_q, strobe_d;
  logic [7:0] scnt_q, scnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    zone_d   = zone_q;
    dial_d   = dial_q;
    dialed_d = dialed_q;

    if (DISARM) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ALARM) begin
            zone_d = ZONE;
            if (PANIC) begin
              state_d = ST_SOUND;
              cnt_d   = SIREN_LOAD;
            end else begin
              state_d = ST_ENTRY;
              cnt_d   = ENTRY_LOAD;
            end
          end
        end
        ST_ENTRY: begin
          zone_d = zone_q | ZONE;
          if (PANIC || cnt_q == 16'd0) begin
            state_d = ST_SOUND;
            cnt_d   = SIREN_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_SOUND: begin
          zone_d = zone_q | ZONE;
          if (cnt_q == 16'd0) begin
            state_d = ST_SILENT;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          zone_d = zone_q | ZONE;
          // Only a fresh 0->1 transition re-arms the siren; a held level does not.
          if (ALARM && !alarm_prev_q) begin
            state_d = ST_SOUND;
            cnt_d   = SIREN_LOAD;
          end
        end
      endcase
    end

    // One request per event; dialed_q remembers it until the event ends in IDLE.
    if (state_d == ST_IDLE) begin
      dial_d   = 1'b0;
      dialed_d = 1'b0;
    end else if (dial_q) begin
      if (ACK) dial_d = 1'b0;
    end else if (!dialed_q && !ACK &&
                 (state_d == ST_SOUND || state_q == ST_SOUND || state_q == ST_SILENT)) begin
      dial_d   = 1'b1;
      dialed_d = 1'b1;
    end
  end

`ifdef ALARM_RESPONDER_STROBE_EN
  always_comb begin
    strobe_d = 1'b0;
    scnt_d   = 8'd0;
    if (state_d == ST_SOUND && state_q != ST_SOUND) begin
      strobe_d = 1'b1;
      scnt_d   = STROBE_LOAD;
    end else if (state_d == ST_SOUND || state_d == ST_SILENT) begin
      if (scnt_q == 8'd0) begin
        strobe_d = !strobe_q;
        scnt_d   = STROBE_LOAD;
      end else begin
        strobe_d = strobe_q;
        scnt_d   = scnt_q - 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      zone_q       <= 3'd0;
      alarm_prev_q <= 1'b0;
      siren_q      <= 1'b0;
      dial_q       <= 1'b0;
      dialed_q     <= 1'b0;
`ifdef ALARM_RESPONDER_STROBE_EN
      strobe_q     <= 1'b0;
      scnt_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      zone_q       <= zone_d;
      alarm_prev_q <= ALARM;
      siren_q      <= (state_d == ST_SOUND);
      dial_q       <= dial_d;
      dialed_q     <= dialed_d;
`ifdef ALARM_RESPONDER_STROBE_EN
      strobe_q     <= strobe_d;
      scnt_q       <= scnt_d;
`endif
    end
  end

  assign SIREN      = siren_q;
  assign DIAL_REQ   = dial_q;
  assign ZONE_LATCH = zone_q;
  assign STATE      = state_q;

`ifdef ALARM_RESPONDER_STROBE_EN
  assign STROBE = strobe_q;
`else
  // STROBE_DIV only shapes the strobe; without it the output is tied low.
  assign STROBE = 1'b0 && (STROBE_DIV > 0);
`endif

endmodule
